mem_chain_sequencer: RTL
========================

# mem_chain_sequencer

Memory-stage access sequencer for the pipelined LC-3b datapath. It sits between the EX/MEM pipeline register and the data cache. It converts one memory instruction into a chain of up to `DEPTH` pointer reads followed by one final read or write. Over the single-level LDI/STI staller it adds configurable indirection depth, flush abort, and a hold state that blocks re-issue while the pipeline is frozen.

## Interface
Parameters:
- `WIDTH`, 16, data/address width in bits; must be a multiple of 8.
- `DEPTH`, 2, maximum pointer levels per request (≥1).
- `LW`, `$clog2(DEPTH+1)`, width of the level field (derived).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  EX/MEM holds a live instruction.
- `req_read`  in  1  final access is a read.
- `req_write`  in  1  final access is a write; wins over `req_read`.
- `req_levels`  in  LW  pointer levels (0 = direct, 1 = LDI/STI, …).
- `req_addr`  in  WIDTH  first address.
- `req_wdata`  in  WIDTH  store data.
- `req_wmask`  in  WIDTH/8  byte mask for final write.
- `pipe_load`  in  1  EX/MEM load enable this cycle.
- `flush`  in  1  squash the current instruction (branch/jump redirect).
- `stall`  out  1  hold upstream pipeline registers.
- `done`  out  1  final access completed this cycle (combinational).
- `rdata`  out  WIDTH  final read data; valid only with `done`.
- `mem_read`, `mem_write`  out  1  dcache strobes.
- `mem_address`  out  WIDTH  dcache address.
- `mem_wdata`  out  WIDTH  dcache write data (= `req_wdata`).
- `mem_wmask`  out  WIDTH/8  dcache byte mask.
- `mem_resp`  in  1  dcache response.
- `mem_rdata`  in  WIDTH  dcache read data.

## Operation
- Registers:
  - `state` ∈ {IDLE, PTR, FINAL, HOLD}.
  - `ptr_q` (WIDTH): current pointer.
  - `cnt_q` (LW): pointer levels remaining.
  - `is_wr_q`: final access is a write.
- Derived signals:
  - `lv = min(req_levels, DEPTH)`: out-of-range levels are clamped.
  - `active = req_valid & (req_read | req_write) & ~flush`.
- Pointer reads always use `mem_read=1`, `mem_write=0`, `mem_wmask` all ones.
- A final access uses `req_wmask` for a write and all ones for a read.
- IDLE:
  - If `active`, issue combinationally.
  - If `lv>0`, issue a pointer read at `req_addr`. On `mem_resp`:
    - `ptr_q<=mem_rdata`, `cnt_q<=lv-1`.
    - Next state is PTR if `lv>1`, else FINAL.
  - If `lv==0`, issue the final access at `req_addr`. On `mem_resp`: `done=1`; next state is IDLE if `pipe_load`, else HOLD.
- PTR:
  - Pointer read at `ptr_q`.
  - On `mem_resp`: `ptr_q<=mem_rdata`, `cnt_q<=cnt_q-1`.
  - Go to FINAL when the decremented count is 0.
- FINAL:
  - Final access at `ptr_q`.
  - On `mem_resp`: `done=1` unless a flush is pending; next state IDLE/HOLD as in IDLE.
- HOLD: no strobes; `stall=0`; `pipe_load` → IDLE. This prevents re-issuing a completed instruction while the pipeline is frozen.
- Stall and read data:
  - `stall = (active | state∈{PTR,FINAL}) & ~done`.
  - `rdata = mem_rdata` when `done & ~is_wr`, else 0.
- Flush behaviour:
  - In IDLE or PTR, or in FINAL with a read: strobes drop that cycle, any `mem_resp` is ignored, next state is IDLE, `done=0`.
  - In FINAL with a write: the write is not aborted. `flush_pend` is set, strobes hold until `mem_resp`, then next state is IDLE with `done=0`.
  - In HOLD: `flush` → IDLE.
- Writes leave `ptr_q` unchanged.

## Timing
- Reset:
  - State: `state=IDLE`, `ptr_q=0`, `cnt_q=0`, `flush_pend=0`, `is_wr_q=0`.
  - Outputs: while `reset_n` is low, `mem_read`, `mem_write`, `stall` and `done` are forced 0.
- Reset asserted mid-chain: the chain is abandoned immediately. After release, the block restarts from IDLE, re-issuing from `req_addr` if the request is still present.
- Latency: `lv` pointer reads + 1 final access. Each access takes ≥1 cycle; there is no bubble between accesses beyond the cache's own latency.
- A zero-wait cache (`mem_resp` same cycle) completes a direct access in 1 cycle, with `stall=0` in that cycle.
- `mem_read`/`mem_write` stay stable until `mem_resp`, except when dropped by flush.
- `done` is a single-cycle pulse per instruction.

## Test plan
- Direct load: `lv=0`, read, `req_addr=0x0040`, resp after 2 cycles with `0xBEEF` → `stall` high 2 cycles; `done`=1 with `rdata=0xBEEF` in the 3rd cycle; next state IDLE (`pipe_load=1`).
- Two-level indirect load (`DEPTH=3`, `lv=2`): mem[0x0100]=0x0200, mem[0x0200]=0x0300, mem[0x0300]=0x1234 → three reads at 0x0100, 0x0200, 0x0300; `rdata=0x1234`.
- STI (`lv=1`, write, `wdata=0x5A5A`, `wmask=2'b01`): mem[0x0010]=0x0080 → read at 0x0010 with mask 2'b11, then write at 0x0080 with mask 2'b01; `rdata=0`.
- Flush during PTR → strobes low the same cycle, late `mem_resp` ignored, `done` never asserted. Flush during the final write → write completes, `done=0`, state IDLE.
- `pipe_load=0` at `done` → HOLD; `req_valid` held 3 cycles with no new strobes and `stall=0`; `pipe_load=1` → IDLE.
- `req_levels=3` with `DEPTH=2` → exactly 2 pointer reads then the final access. `reset_n` pulsed low mid-PTR → strobes 0 and state IDLE.

Source files
------------

// File: rtl/mem_chain_sequencer_if.sv
// rtl/mem_chain_sequencer_if.sv - request, pipeline-control and dcache bundle for the memory-stage chain sequencer
interface mem_chain_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int LW    = $clog2(DEPTH + 1)
);
    // EX/MEM request
    logic                 req_valid;
    logic                 req_read;
    logic                 req_write;
    logic [LW-1:0]        req_levels;
    logic [WIDTH-1:0]     req_addr;
    logic [WIDTH-1:0]     req_wdata;
    logic [WIDTH/8-1:0]   req_wmask;
    // pipeline control
    logic                 pipe_load;
    logic                 flush;
    logic                 stall;
    logic                 done;
    logic [WIDTH-1:0]     rdata;
    // dcache port
    logic                 mem_read;
    logic                 mem_write;
    logic [WIDTH-1:0]     mem_address;
    logic [WIDTH-1:0]     mem_wdata;
    logic [WIDTH/8-1:0]   mem_wmask;
    logic                 mem_resp;
    logic [WIDTH-1:0]     mem_rdata;

    // pipeline + dcache side
    modport master (
        output req_valid, req_read, req_write, req_levels, req_addr, req_wdata, req_wmask,
        output pipe_load, flush, mem_resp, mem_rdata,
        input  stall, done, rdata, mem_read, mem_write, mem_address, mem_wdata, mem_wmask
    );

    // sequencer side
    modport slave (
        input  req_valid, req_read, req_write, req_levels, req_addr, req_wdata, req_wmask,
        input  pipe_load, flush, mem_resp, mem_rdata,
        output stall, done, rdata, mem_read, mem_write, mem_address, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_chain_sequencer.sv
// rtl/mem_chain_sequencer.sv - turns one memory instruction into a pointer-read chain plus a final read/write
module mem_chain_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mem_chain_sequencer_if.slave  bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int MW = WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PTR   = 2'd1,
        S_FINAL = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_ptr;
    logic [LW-1:0]    r_cnt;
    logic             r_is_wr;
    logic             r_flush_pend;

    state_t           w_state_n;
    logic [WIDTH-1:0] w_ptr_n;
    logic [LW-1:0]    w_cnt_n;
    logic             w_is_wr_n;
    logic             w_flush_pend_n;

    logic [LW-1:0]    w_lv;
    logic             w_active;
    logic             w_rd;
    logic             w_wr;
    logic [WIDTH-1:0] w_addr;
    logic [MW-1:0]    w_mask;
    logic             w_done;
    logic             w_final_wr;

    // Requested indirection beyond DEPTH is clamped rather than rejected.
    assign w_lv     = (bus.req_levels > LW'(DEPTH)) ? LW'(DEPTH) : bus.req_levels;
    assign w_active = bus.req_valid & (bus.req_read | bus.req_write) & ~bus.flush;

    // Direct accesses complete from IDLE before r_is_wr is captured, so read the request there.
    assign w_final_wr = (r_state == S_IDLE) ? bus.req_write : r_is_wr;

    // State and chain registers; reset abandons any chain in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_is_wr      <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_ptr        <= w_ptr_n;
            r_cnt        <= w_cnt_n;
            r_is_wr      <= w_is_wr_n;
            r_flush_pend <= w_flush_pend_n;
        end
    end

    // Next-state, dcache strobes and completion pulse.
    always_comb begin
        w_state_n      = r_state;
        w_ptr_n        = r_ptr;
        w_cnt_n        = r_cnt;
        w_is_wr_n      = r_is_wr;
        w_flush_pend_n = r_flush_pend;
        w_rd           = 1'b0;
        w_wr           = 1'b0;
        w_addr         = r_ptr;
        w_mask         = '1;
        w_done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_active) begin
                    w_addr = bus.req_addr;
                    if (w_lv != '0) begin
                        w_rd = 1'b1;
                        if (bus.mem_resp) begin
                            w_ptr_n   = bus.mem_rdata;
                            w_cnt_n   = w_lv - LW'(1);
                            w_is_wr_n = bus.req_write;
                            w_state_n = (w_lv > LW'(1)) ? S_PTR : S_FINAL;
                        end
                    end else begin
                        w_rd   = ~bus.req_write;
                        w_wr   = bus.req_write;
                        w_mask = bus.req_write ? bus.req_wmask : '1;
                        if (bus.mem_resp) begin
                            w_done    = 1'b1;
                            w_is_wr_n = bus.req_write;
                            w_state_n = bus.pipe_load ? S_IDLE : S_HOLD;
                        end
                    end
                end
            end
            S_PTR: begin
                if (bus.flush) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_rd = 1'b1;
                    if (bus.mem_resp) begin
                        w_ptr_n = bus.mem_rdata;
                        w_cnt_n = r_cnt - LW'(1);
                        if (r_cnt == LW'(1)) begin
                            w_state_n = S_FINAL;
                        end
                    end
                end
            end
            S_FINAL: begin
                if (r_is_wr) begin
                    // A write already on the bus must finish; a flush only suppresses done.
                    w_wr   = 1'b1;
                    w_mask = bus.req_wmask;
                    if (bus.mem_resp) begin
                        w_flush_pend_n = 1'b0;
                        if (bus.flush || r_flush_pend) begin
                            w_state_n = S_IDLE;
                        end else begin
                            w_done    = 1'b1;
                            w_state_n = bus.pipe_load ? S_IDLE : S_HOLD;
                        end
                    end else if (bus.flush) begin
                        w_flush_pend_n = 1'b1;
                    end
                end else if (bus.flush) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_rd = 1'b1;
                    if (bus.mem_resp) begin
                        w_done    = 1'b1;
                        w_state_n = bus.pipe_load ? S_IDLE : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.flush || bus.pipe_load) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Control outputs are forced low while reset is asserted.
    assign bus.mem_read    = w_rd & reset_n;
    assign bus.mem_write   = w_wr & reset_n;
    assign bus.mem_address = w_addr;
    assign bus.mem_wdata   = bus.req_wdata;
    assign bus.mem_wmask   = w_mask;
    assign bus.done        = w_done & reset_n;
    assign bus.stall       = reset_n & ~w_done &
                             (((r_state == S_IDLE) & w_active) | (r_state == S_PTR) | (r_state == S_FINAL));
    assign bus.rdata       = (bus.done & ~w_final_wr) ? bus.mem_rdata : '0;
endmodule
